// File: rtl/cmp_debounce_fsm.sv
// cmp_debounce_fsm: debounced, hysteretic "A above B" level from comparator flags
module cmp_debounce_fsm #(
  parameter int DEBOUNCE = 3,
  parameter int CNT_W    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic             gt,
  input  logic             eq,
  input  logic             lt,
  output logic             above,
  output logic             rise,
  output logic             fall,
  output logic             err,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] cnt
);
  typedef enum logic [1:0] {
    S_LOW       = 2'b00,
    S_RISE_PEND = 2'b01,
    S_HIGH      = 2'b10,
    S_FALL_PEND = 2'b11
  } state_t;

  localparam logic [CNT_W-1:0] DEB = CNT_W'(DEBOUNCE);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_rise;
  logic             r_fall;
  logic             r_err;

  logic             w_onehot;
  logic             w_valid;
  logic [CNT_W-1:0] w_n;

  assign w_onehot = ({gt, eq, lt} == 3'b100) || ({gt, eq, lt} == 3'b010) || ({gt, eq, lt} == 3'b001);
  assign w_valid  = en && w_onehot;
  assign w_n      = r_cnt + 1'b1;

  // State, count and event pulses all update together on the sample edge; clr beats any sample
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_LOW;
      r_cnt   <= '0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
      r_err   <= 1'b0;
    end else if (clr) begin
      r_state <= S_LOW;
      r_cnt   <= '0;
      r_rise  <= 1'b0;
      r_err   <= 1'b0;
      r_fall  <= r_state[1];
    end else begin
      r_rise <= 1'b0;
      r_fall <= 1'b0;
      r_err  <= en && !w_onehot;
      if (w_valid) begin
        case (r_state)
          S_LOW: begin
            if (gt && DEBOUNCE == 1) begin
              r_state <= S_HIGH;
              r_rise  <= 1'b1;
              r_cnt   <= '0;
            end else if (gt) begin
              r_state <= S_RISE_PEND;
              r_cnt   <= CNT_W'(1);
            end else begin
              r_cnt   <= '0;
            end
          end
          S_RISE_PEND: begin
            if (gt && w_n == DEB) begin
              r_state <= S_HIGH;
              r_rise  <= 1'b1;
              r_cnt   <= '0;
            end else if (gt) begin
              r_cnt   <= w_n;
            end else if (lt) begin
              r_state <= S_LOW;
              r_cnt   <= '0;
            end
          end
          S_HIGH: begin
            if (lt && DEBOUNCE == 1) begin
              r_state <= S_LOW;
              r_fall  <= 1'b1;
              r_cnt   <= '0;
            end else if (lt) begin
              r_state <= S_FALL_PEND;
              r_cnt   <= CNT_W'(1);
            end else begin
              r_cnt   <= '0;
            end
          end
          default: begin
            if (lt && w_n == DEB) begin
              r_state <= S_LOW;
              r_fall  <= 1'b1;
              r_cnt   <= '0;
            end else if (lt) begin
              r_cnt   <= w_n;
            end else if (gt) begin
              r_state <= S_HIGH;
              r_cnt   <= '0;
            end
          end
        endcase
      end
    end
  end

  // HIGH and FALL_PEND share the upper encoding bit, so the level is a direct state decode
  assign above = r_state[1];
  assign rise  = r_rise;
  assign fall  = r_fall;
  assign err   = r_err;
  assign state = r_state;
  assign cnt   = r_cnt;
endmodule

// File: tb/tb_cmp_debounce_fsm.sv
// tb_cmp_debounce_fsm: scoreboard bench for cmp_debounce_fsm (DEBOUNCE=3 and DEBOUNCE=1 builds)
module tb_cmp_debounce_fsm;
  typedef struct {
    logic [9:0] v;
    string      name;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic a_clr = 1'b0, a_en = 1'b0, a_gt = 1'b0, a_eq = 1'b0, a_lt = 1'b0;
  logic b_clr = 1'b0, b_en = 1'b0, b_gt = 1'b0, b_eq = 1'b0, b_lt = 1'b0;
  logic a_above, a_rise, a_fall, a_err;
  logic b_above, b_rise, b_fall, b_err;
  logic [1:0] a_state, b_state;
  logic [3:0] a_cnt, b_cnt;

  exp_t q3[$];
  exp_t q1[$];
  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  cmp_debounce_fsm #(.DEBOUNCE(3), .CNT_W(4)) u_d3 (
    .clk(clk), .rst_n(rst_n), .clr(a_clr), .en(a_en), .gt(a_gt), .eq(a_eq), .lt(a_lt),
    .above(a_above), .rise(a_rise), .fall(a_fall), .err(a_err), .state(a_state), .cnt(a_cnt)
  );

  cmp_debounce_fsm #(.DEBOUNCE(1), .CNT_W(4)) u_d1 (
    .clk(clk), .rst_n(rst_n), .clr(b_clr), .en(b_en), .gt(b_gt), .eq(b_eq), .lt(b_lt),
    .above(b_above), .rise(b_rise), .fall(b_fall), .err(b_err), .state(b_state), .cnt(b_cnt)
  );

  function automatic logic [9:0] pack(input logic [1:0] st, input logic [3:0] c, input logic ab,
                                      input logic r, input logic f, input logic e);
    return {st, c, ab, r, f, e};
  endfunction

  task automatic check(input string name, input logic [9:0] act, input logic [9:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got st=%b cnt=%0d above=%b rise=%b fall=%b err=%b, want st=%b cnt=%0d above=%b rise=%b fall=%b err=%b",
               name, act[9:8], act[7:4], act[3], act[2], act[1], act[0],
               exp[9:8], exp[7:4], exp[3], exp[2], exp[1], exp[0]);
    end
  endtask

  // drive DEBOUNCE=3 instance; flags = {gt,eq,lt}
  task automatic s3(input string name, input logic clr, input logic en, input logic [2:0] f,
                    input logic [1:0] st, input logic [3:0] c, input logic ab,
                    input logic r, input logic fl, input logic e);
    exp_t x;
    @(negedge clk);
    a_clr = clr; a_en = en; {a_gt, a_eq, a_lt} = f;
    x.v = pack(st, c, ab, r, fl, e);
    x.name = name;
    q3.push_back(x);
  endtask

  task automatic s1(input string name, input logic clr, input logic en, input logic [2:0] f,
                    input logic [1:0] st, input logic [3:0] c, input logic ab,
                    input logic r, input logic fl, input logic e);
    exp_t x;
    @(negedge clk);
    b_clr = clr; b_en = en; {b_gt, b_eq, b_lt} = f;
    x.v = pack(st, c, ab, r, fl, e);
    x.name = name;
    q1.push_back(x);
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((q3.size() != 0 || q1.size() != 0) && k < 10) begin
      @(posedge clk);
      #2;
      k++;
    end
    n_chk++;
    if (q3.size() != 0 || q1.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d/%0d expectations left, want 0", q3.size(), q1.size());
    end
  endtask

  // monitor: outputs are valid every cycle, so compare one expectation per edge
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (q3.size() != 0) begin
        x = q3.pop_front();
        check(x.name, pack(a_state, a_cnt, a_above, a_rise, a_fall, a_err), x.v);
      end
      if (q1.size() != 0) begin
        x = q1.pop_front();
        check(x.name, pack(b_state, b_cnt, b_above, b_rise, b_fall, b_err), x.v);
      end
    end
  end

  initial begin
    #3;
    check("reset_d3", pack(a_state, a_cnt, a_above, a_rise, a_fall, a_err), 10'b0);
    check("reset_d1", pack(b_state, b_cnt, b_above, b_rise, b_fall, b_err), 10'b0);
    @(negedge clk);
    rst_n = 1'b1;
    // 1: gt x3
    s3("t1_gt1", 0, 1, 3'b100, 2'b01, 1, 0, 0, 0, 0);
    s3("t1_gt2", 0, 1, 3'b100, 2'b01, 2, 0, 0, 0, 0);
    s3("t1_gt3", 0, 1, 3'b100, 2'b10, 0, 1, 1, 0, 0);
    s3("high_eq", 0, 1, 3'b010, 2'b10, 0, 1, 0, 0, 0);
    // 3: lt,lt,gt from HIGH
    s3("t3_lt1", 0, 1, 3'b001, 2'b11, 1, 1, 0, 0, 0);
    s3("t3_lt2", 0, 1, 3'b001, 2'b11, 2, 1, 0, 0, 0);
    s3("t3_gt", 0, 1, 3'b100, 2'b10, 0, 1, 0, 0, 0);
    // 4: illegal flags then idle
    s3("t4_err", 0, 1, 3'b110, 2'b10, 0, 1, 0, 0, 1);
    s3("t4_idle", 0, 0, 3'b000, 2'b10, 0, 1, 0, 0, 0);
    // full fall
    s3("fall_lt1", 0, 1, 3'b001, 2'b11, 1, 1, 0, 0, 0);
    s3("fall_lt2", 0, 1, 3'b001, 2'b11, 2, 1, 0, 0, 0);
    s3("fall_lt3", 0, 1, 3'b001, 2'b00, 0, 0, 0, 1, 0);
    // 2: gt,gt,eq,eq,gt from LOW
    s3("t2_gt1", 0, 1, 3'b100, 2'b01, 1, 0, 0, 0, 0);
    s3("t2_gt2", 0, 1, 3'b100, 2'b01, 2, 0, 0, 0, 0);
    s3("t2_eq1", 0, 1, 3'b010, 2'b01, 2, 0, 0, 0, 0);
    s3("t2_eq2", 0, 1, 3'b010, 2'b01, 2, 0, 0, 0, 0);
    s3("t2_gt3", 0, 1, 3'b100, 2'b10, 0, 1, 1, 0, 0);
    // FALL_PEND eq hold, then clr gives fall
    s3("fp_lt", 0, 1, 3'b001, 2'b11, 1, 1, 0, 0, 0);
    s3("fp_eq", 0, 1, 3'b010, 2'b11, 1, 1, 0, 0, 0);
    s3("fp_clr", 1, 1, 3'b001, 2'b00, 0, 0, 0, 1, 0);
    s3("low_clr", 1, 1, 3'b111, 2'b00, 0, 0, 0, 0, 0);
    s3("low_err0", 0, 1, 3'b000, 2'b00, 0, 0, 0, 0, 1);
    s3("low_eq", 0, 1, 3'b010, 2'b00, 0, 0, 0, 0, 0);
    s3("rp_gt", 0, 1, 3'b100, 2'b01, 1, 0, 0, 0, 0);
    s3("rp_err", 0, 1, 3'b111, 2'b01, 1, 0, 0, 0, 1);
    s3("rp_lt", 0, 1, 3'b001, 2'b00, 0, 0, 0, 0, 0);
    // 5: reach FALL_PEND cnt=2, then async reset mid-cycle
    s3("t5_gt1", 0, 1, 3'b100, 2'b01, 1, 0, 0, 0, 0);
    s3("t5_gt2", 0, 1, 3'b100, 2'b01, 2, 0, 0, 0, 0);
    s3("t5_gt3", 0, 1, 3'b100, 2'b10, 0, 1, 1, 0, 0);
    s3("t5_lt1", 0, 1, 3'b001, 2'b11, 1, 1, 0, 0, 0);
    s3("t5_lt2", 0, 1, 3'b001, 2'b11, 2, 1, 0, 0, 0);
    a_en = 1'b1;
    drain();
    a_en = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    check("t5_async_rst", pack(a_state, a_cnt, a_above, a_rise, a_fall, a_err), 10'b0);
    @(negedge clk);
    rst_n = 1'b1;
    // 6: DEBOUNCE=1
    s1("t6_gt", 0, 1, 3'b100, 2'b10, 0, 1, 1, 0, 0);
    s1("t6_lt", 0, 1, 3'b001, 2'b00, 0, 0, 0, 1, 0);
    s1("t6_gt2", 0, 1, 3'b100, 2'b10, 0, 1, 1, 0, 0);
    s1("t6_gt_hold", 0, 1, 3'b100, 2'b10, 0, 1, 0, 0, 0);
    s1("t6_clr", 1, 1, 3'b001, 2'b00, 0, 0, 0, 1, 0);
    s1("t6_clr_gt", 1, 1, 3'b100, 2'b00, 0, 0, 0, 0, 0);
    s1("t6_idle", 0, 0, 3'b000, 2'b00, 0, 0, 0, 0, 0);
    drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
